// File: rtl/risc16_ctrl_if.sv
// Bus bundle between the RISC16 sequencing controller and its datapath/environment.
// The environment side (instruction source, ALU compare, memory) uses master.
interface risc16_ctrl_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;

   logic [1:0]  FUNC_alu;
   logic        MUX_alu1;
   logic        MUX_alu2;
   logic [9:0]  imm;
   logic        EQ;

   logic [2:0]  rf_src1;
   logic [2:0]  rf_src2;
   logic [2:0]  rf_wsel;
   logic        rf_we;
   logic [1:0]  wb_sel;

   logic        mem_req;
   logic        mem_we;
   logic        mem_ack;

   logic        pc_we;
   logic [1:0]  pc_sel;

   logic        busy;
   logic        halted;
   logic [15:0] retire_cnt;

   modport master (
      output instr_valid, instr, EQ, mem_ack,
      input  instr_ready, FUNC_alu, MUX_alu1, MUX_alu2, imm,
      input  rf_src1, rf_src2, rf_wsel, rf_we, wb_sel,
      input  mem_req, mem_we, pc_we, pc_sel, busy, halted, retire_cnt
   );

   modport slave (
      input  instr_valid, instr, EQ, mem_ack,
      output instr_ready, FUNC_alu, MUX_alu1, MUX_alu2, imm,
      output rf_src1, rf_src2, rf_wsel, rf_we, wb_sel,
      output mem_req, mem_we, pc_we, pc_sel, busy, halted, retire_cnt
   );
endinterface

// File: rtl/risc16_ctrl.sv
// Multi-cycle sequencing controller for a 16-bit RISC core: accepts one instruction,
// steps it through EXEC / MEM / WB and issues ALU, register-file, memory and PC controls.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an instruction; instr_ready high once out of reset
// EXEC  | ALU evaluates; BEQ retires here, halt-JALR diverts to HALT
// MEM   | mem_req held until mem_ack (SW retires on ack, LW goes to WB)
// WB    | register write-back and PC update for ALU ops, LW and JALR
// HALT  | parked until reset, no handshake accepted
module risc16_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   risc16_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXEC = 3'd1,
      S_MEM  = 3'd2,
      S_WB   = 3'd3,
      S_HALT = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_ADDI = 3'b001,
      OP_NAND = 3'b010,
      OP_LUI  = 3'b011,
      OP_SW   = 3'b100,
      OP_LW   = 3'b101,
      OP_BEQ  = 3'b110,
      OP_JALR = 3'b111
   } opcode_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] retire_q;
   logic        rdy_en_q;

   opcode_t     op;
   logic [2:0]  ra, rb, rc;
   logic        active;

   logic [1:0]  func_c;
   logic        mux1_c, mux2_c;
   logic [2:0]  src1_c, src2_c;

   logic        instr_ready_c;
   logic        rf_we_c;
   logic [1:0]  wb_sel_c;
   logic        mem_req_c, mem_we_c;
   logic        pc_we_c;
   logic [1:0]  pc_sel_c;

   assign op     = opcode_t'(instr_q[15:13]);
   assign ra     = instr_q[12:10];
   assign rb     = instr_q[9:7];
   assign rc     = instr_q[2:0];
   assign active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

   // rdy_en_q keeps instr_ready low while reset is asserted and up to the first edge after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         instr_q  <= 16'h0000;
         retire_q <= 16'h0000;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         rdy_en_q <= 1'b1;
         if (pc_we_c) begin
            retire_q <= retire_q + 16'd1;
         end
      end
   end

   always_comb begin
      func_c = 2'b00;
      mux1_c = 1'b0;
      mux2_c = 1'b0;
      unique case (op)
         OP_ADD:  begin func_c = 2'b00;                 end
         OP_ADDI: begin func_c = 2'b00; mux2_c = 1'b1;  end
         OP_NAND: begin func_c = 2'b01;                 end
         OP_LUI:  begin func_c = 2'b10; mux1_c = 1'b1;  end
         OP_SW:   begin func_c = 2'b00; mux2_c = 1'b1;  end
         OP_LW:   begin func_c = 2'b00; mux2_c = 1'b1;  end
         OP_BEQ:  begin func_c = 2'b11;                 end
         OP_JALR: begin func_c = 2'b10;                 end
         default: begin func_c = 2'b00;                 end
      endcase
   end

   always_comb begin
      src1_c = (op == OP_BEQ) ? ra : rb;
      unique case (op)
         OP_ADD, OP_NAND: src2_c = rc;
         OP_SW:           src2_c = ra;
         OP_BEQ:          src2_c = rb;
         default:         src2_c = 3'd0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_ready_c = 1'b0;
      rf_we_c       = 1'b0;
      wb_sel_c      = 2'b00;
      mem_req_c     = 1'b0;
      mem_we_c      = 1'b0;
      pc_we_c       = 1'b0;
      pc_sel_c      = 2'b00;

      unique case (state_q)
         S_IDLE: begin
            instr_ready_c = rdy_en_q;
            if (bus.instr_valid && rdy_en_q) begin
               instr_d = bus.instr;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            unique case (op)
               OP_BEQ: begin
                  pc_we_c  = 1'b1;
                  pc_sel_c = bus.EQ ? 2'b01 : 2'b00;
                  state_d  = S_IDLE;
               end
               OP_SW, OP_LW: begin
                  state_d = S_MEM;
               end
               OP_JALR: begin
                  // A non-zero 7-bit immediate on JALR is the halt encoding.
                  state_d = (instr_q[6:0] == 7'd0) ? S_WB : S_HALT;
               end
               default: begin
                  state_d = S_WB;
               end
            endcase
         end

         S_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = (op == OP_SW);
            if (bus.mem_ack) begin
               if (op == OP_SW) begin
                  pc_we_c = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            rf_we_c = (ra != 3'd0);
            pc_we_c = 1'b1;
            unique case (op)
               OP_LW:   wb_sel_c = 2'b01;
               OP_JALR: wb_sel_c = 2'b10;
               default: wb_sel_c = 2'b00;
            endcase
            pc_sel_c = (op == OP_JALR) ? 2'b10 : 2'b00;
            state_d  = S_IDLE;
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.instr_ready = instr_ready_c;
   assign bus.FUNC_alu    = active ? func_c : 2'b00;
   assign bus.MUX_alu1    = active ? mux1_c : 1'b0;
   assign bus.MUX_alu2    = active ? mux2_c : 1'b0;
   assign bus.imm         = active ? instr_q[9:0] : 10'd0;

   assign bus.rf_src1     = src1_c;
   assign bus.rf_src2     = src2_c;
   assign bus.rf_wsel     = ra;
   assign bus.rf_we       = rf_we_c;
   assign bus.wb_sel      = wb_sel_c;

   assign bus.mem_req     = mem_req_c;
   assign bus.mem_we      = mem_we_c;

   assign bus.pc_we       = pc_we_c;
   assign bus.pc_sel      = pc_sel_c;

   assign bus.busy        = active;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.retire_cnt  = retire_q;

endmodule

// File: tb/tb_risc16_ctrl.sv
// Bench for risc16_ctrl: random and directed instructions, expected per-instruction
// behaviour queued at issue and compared by an independent per-cycle monitor.
module tb_risc16_ctrl;

   logic clk;
   logic rst_n;

   risc16_ctrl_if bus ();

   risc16_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  alu;
      logic [9:0]  imm;
      logic [2:0]  src1;
      logic [2:0]  src2;
      logic [2:0]  wsel;
      logic        rf_we;
      logic [1:0]  wb_sel;
      logic [1:0]  pc_sel;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        mon_en   = 1'b0;
   logic [15:0] model_cnt = 16'd0;
   int          mem_wait = 0;

   // {FUNC_alu, MUX_alu1, MUX_alu2} indexed by opcode
   logic [3:0] alu_tbl [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b1010,
                               4'b0001, 4'b0001, 4'b1100, 4'b1000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] ins, input logic eq);
      exp_t       e;
      logic [2:0] opc, a, b, c;
      opc      = ins[15:13];
      a        = ins[12:10];
      b        = ins[9:7];
      c        = ins[2:0];
      e.op     = opc;
      e.alu    = alu_tbl[opc];
      e.imm    = ins[9:0];
      e.src1   = (opc == 3'd6) ? a : b;
      e.src2   = (opc == 3'd0 || opc == 3'd2) ? c :
                 (opc == 3'd4) ? a :
                 (opc == 3'd6) ? b : 3'd0;
      e.wsel   = a;
      e.rf_we  = (opc != 3'd4) && (opc != 3'd6) && (a != 3'd0);
      e.wb_sel = (opc == 3'd5) ? 2'b01 : (opc == 3'd7) ? 2'b10 : 2'b00;
      e.pc_sel = (opc == 3'd6) ? (eq ? 2'b01 : 2'b00) : (opc == 3'd7) ? 2'b10 : 2'b00;
      return e;
   endfunction

   function automatic int latency(input logic [2:0] opc, input int w);
      if (opc == 3'd6) return 1;
      if (opc == 3'd4) return 2 + w;
      if (opc == 3'd5) return 3 + w;
      return 2;
   endfunction

   // Memory responder; when no request is pending, mem_ack is random noise.
   int ack_cnt = 0;
   initial begin
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req) begin
            if (ack_cnt >= mem_wait) begin
               bus.mem_ack = 1'b1;
            end else begin
               bus.mem_ack = 1'b0;
               ack_cnt++;
            end
         end else begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            ack_cnt     = 0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en && rst_n) begin
         if (bus.busy) begin
            if (exp_q.size() == 0) begin
               chk("busy_without_instr", 32'(bus.busy), 32'd0);
            end else begin
               e = exp_q[0];
               chk("alu_ctrl", {bus.FUNC_alu, bus.MUX_alu1, bus.MUX_alu2}, e.alu);
               chk("imm", bus.imm, e.imm);
               chk("rf_src1", bus.rf_src1, e.src1);
               chk("rf_src2", bus.rf_src2, e.src2);
               chk("mem_we", bus.mem_we, bus.mem_req && (e.op == 3'd4));
               if (bus.mem_req) chk("mem_req_op", (e.op == 3'd4 || e.op == 3'd5), 1);
               if (bus.pc_we) begin
                  chk("pc_sel", bus.pc_sel, e.pc_sel);
                  chk("rf_we", bus.rf_we, e.rf_we);
                  chk("wb_sel", bus.wb_sel, e.wb_sel);
                  chk("rf_wsel", bus.rf_wsel, e.wsel);
                  chk("retire_cnt", bus.retire_cnt, model_cnt);
                  model_cnt = model_cnt + 16'd1;
                  void'(exp_q.pop_front());
               end else begin
                  chk("rf_we_no_retire", bus.rf_we, 0);
               end
            end
         end else begin
            chk("idle_ctrl",
                {bus.FUNC_alu, bus.MUX_alu1, bus.MUX_alu2, bus.rf_we, bus.mem_req,
                 bus.mem_we, bus.pc_we, bus.pc_sel, bus.wb_sel, bus.halted}, 0);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.instr_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.instr_ready) chk("wait_ready_timeout", 0, 1);
   endtask

   task automatic issue(input logic [15:0] ins, input logic eq, input int w);
      int lat;
      exp_t e;
      wait_ready();
      e               = model(ins, eq);
      bus.EQ          = eq;
      mem_wait        = w;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      // noise on the handshake while busy must be ignored
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr       = 16'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.instr_ready && lat < 100);
      bus.instr_valid = 1'b0;
      chk("latency", lat, latency(e.op, w));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ins;
      int n;
      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0000;
      bus.EQ          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.instr_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_retire", bus.retire_cnt, 0);
      chk("rst_ctrl", {bus.FUNC_alu, bus.MUX_alu1, bus.MUX_alu2, bus.rf_we, bus.mem_req,
                       bus.mem_we, bus.pc_we, bus.pc_sel, bus.wb_sel, bus.imm}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_before_first_edge", bus.instr_ready, 0);
      @(posedge clk);
      #1;
      chk("ready_after_release", bus.instr_ready, 1);
      mon_en = 1'b1;

      issue(16'h0503, 1'b0, 0);   // ADD r1,r2,r3
      issue(16'h6333, 1'b1, 0);   // LUI r0,0x333
      issue(16'hC504, 1'b1, 0);   // BEQ r1,r2,+4 taken
      issue(16'hC504, 1'b0, 0);   // BEQ not taken
      issue(16'hB2F4, 1'b0, 3);   // LW r4,r5,-12, ack after 3 waits
      issue(16'h9284, 1'b0, 0);   // SW r4,r5,4 immediate ack
      issue(16'hFF00, 1'b0, 0);   // JALR r7,r6

      for (int i = 0; i < 150; i++) begin
         ins = 16'($urandom);
         if (ins[15:13] == 3'd7) ins[6:0] = 7'd0;
         issue(ins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      end
      wait_ready();
      chk("queue_drained", exp_q.size(), 0);

      // reset while a load is waiting on memory
      issue(16'h0503, 1'b0, 0);
      wait_ready();
      mem_wait        = 30;
      bus.instr       = 16'hB2F4;
      bus.instr_valid = 1'b1;
      exp_q.push_back(model(16'hB2F4, 1'b0));
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      n = 0;
      while (!bus.mem_req && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mem_req_seen", bus.mem_req, 1);
      repeat (2) @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_retire", bus.retire_cnt, 0);
      chk("rst_mid_ready", bus.instr_ready, 0);
      exp_q.delete();
      model_cnt = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_ready_pre", bus.instr_ready, 0);
      @(posedge clk);
      #1;
      chk("rst_mid_ready_post", bus.instr_ready, 1);
      mon_en = 1'b1;
      issue(16'h0503, 1'b0, 0);
      issue(16'hB2F4, 1'b0, 1);
      wait_ready();
      chk("retire_after_reset", bus.retire_cnt, 2);

      // halt: JALR with non-zero immediate
      mon_en          = 1'b0;
      bus.instr       = 16'hE001;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("halt_exec_busy", bus.busy, 1);
      chk("halt_exec_pc_we", bus.pc_we, 0);
      for (int i = 0; i < 6; i++) begin
         bus.instr = 16'h0503;
         @(posedge clk);
         #1;
         chk("halted", bus.halted, 1);
         chk("halt_ready", bus.instr_ready, 0);
         chk("halt_pc_we", bus.pc_we, 0);
         chk("halt_busy", bus.busy, 0);
      end
      chk("halt_retire", bus.retire_cnt, model_cnt);
      bus.instr_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
